// File: rtl/gray_sync_decoder.sv
// Synchronizes an asynchronous Gray-coded count into the clk domain, decodes it
// to binary, and classifies each new sample as a legal single-bit step or an error.
module gray_sync_decoder #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic [N:0]   gray_in,
  output logic [N:0]   bin_out,
  output logic         step_valid,
  output logic         step_up,
  output logic         err,
  output logic [7:0]   err_cnt,
  output logic         locked
);

  localparam int unsigned W       = N + 1;
  localparam int unsigned CNT_W   = 8;
  localparam logic [7:0]  CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {FILL, PRIME, RUN} state_e;

  state_e         state_q;
  logic           fill_cnt_q;
  logic [W-1:0]   sync1_q;
  logic [W-1:0]   sync2_q;
  logic [W-1:0]   prev_q;
  logic [W-1:0]   bin_q;
  logic           step_valid_q;
  logic           step_up_q;
  logic           err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic           locked_q;

  logic [W-1:0]   bin_d;
  logic [W-1:0]   prev_bin_c;
  logic [W-1:0]   diff_c;
  logic           one_bit_c;
  logic           multi_bit_c;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    b[W-1] = g[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A legal Gray step flips exactly one bit: nonzero and a power of two.
  always_comb begin
    bin_d       = g2b(sync2_q);
    prev_bin_c  = g2b(prev_q);
    diff_c      = sync2_q ^ prev_q;
    one_bit_c   = (diff_c != '0) && ((diff_c & (diff_c - W'(1))) == '0);
    multi_bit_c = (diff_c != '0) && !one_bit_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      fill_cnt_q   <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      bin_q        <= '0;
      step_valid_q <= 1'b0;
      step_up_q    <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      locked_q     <= 1'b0;
    end else begin
      // Pulses last exactly one cycle and never fire on disabled edges.
      step_valid_q <= 1'b0;
      err_q        <= 1'b0;
      if (clk_en) begin
        sync1_q <= gray_in;
        sync2_q <= sync1_q;
        case (state_q)
          FILL: begin
            if (fill_cnt_q) begin
              state_q    <= PRIME;
              fill_cnt_q <= 1'b0;
            end else begin
              fill_cnt_q <= 1'b1;
            end
          end
          PRIME: begin
            prev_q   <= sync2_q;
            bin_q    <= bin_d;
            state_q  <= RUN;
            locked_q <= 1'b1;
          end
          RUN: begin
            // Errors still resynchronize bin_out and prev to the new sample.
            prev_q <= sync2_q;
            bin_q  <= bin_d;
            if (one_bit_c) begin
              step_valid_q <= 1'b1;
              step_up_q    <= (bin_d == prev_bin_c + W'(1));
            end else if (multi_bit_c) begin
              err_q <= 1'b1;
              if (err_cnt_q != CNT_MAX) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
              end
            end
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  assign bin_out    = bin_q;
  assign step_valid = step_valid_q;
  assign step_up    = step_up_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
  assign locked     = locked_q;

endmodule

// File: doc/gray_sync_decoder.md
GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

Interface
REQ-001 Parameter N, default 4, counter MSB index; all code buses are N+1 bits wide.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high; sampled on rising clk edge.
REQ-004 clk_en  input  1  sample enable; block advances only on edges where clk_en=1.
REQ-005 gray_in  input  N+1  Gray-coded count from upstream counter, possibly asynchronous to clk.
REQ-006 bin_out  output  N+1  registered binary equivalent of the synchronized Gray sample.
REQ-007 step_valid  output  1  one-cycle pulse: legal single-bit Gray change accepted.
REQ-008 step_up  output  1  direction of the last legal step: 1 = +1, 0 = -1 or other.
REQ-009 err  output  1  one-cycle pulse: more than one Gray bit changed between samples.
REQ-010 err_cnt  output  8  saturating count of err pulses since reset.
REQ-011 locked  output  1  high while the FSM is in RUN.

Function
REQ-012 Datapath SHALL be a two-stage synchronizer (sync1<=gray_in, sync2<=sync1) plus a previous-sample register prev<=sync2, all advancing only on enabled edges.
REQ-013 Gray-to-binary SHALL be b[N]=g[N], b[i]=b[i+1] XOR g[i] for i=N-1..0; bin_out<=g2b(sync2) on every enabled edge in PRIME and RUN.
REQ-014 Latency: a gray_in value stable before enabled edge k SHALL appear on bin_out, with step_valid/err, after enabled edge k+2.
REQ-015 FSM states: FILL, PRIME, RUN; FILL -> PRIME after 2 enabled edges, PRIME -> RUN after 1 enabled edge, RUN holds until reset.
REQ-016 In FILL and PRIME, step_valid and err SHALL be 0 and err_cnt SHALL not change; PRIME loads prev and bin_out only.
REQ-017 In RUN, on each enabled edge, let d = sync2 XOR prev: popcount(d)=0 -> no pulse; popcount(d)=1 -> step_valid=1; popcount(d)>=2 -> err=1.
REQ-018 On step_valid, step_up SHALL be 1 iff g2b(sync2) = g2b(prev)+1 mod 2^(N+1), else 0; step_up holds its value between steps.
REQ-019 Wrap-around: all-ones binary to zero SHALL count as step_up=1; zero to all-ones SHALL count as step_up=0.
REQ-020 On err, bin_out SHALL still load g2b(sync2) (resynchronize) and prev SHALL load sync2; step_up unchanged.
REQ-021 err_cnt SHALL increment by 1 per err pulse and saturate at 255, never wrapping.
REQ-022 step_valid and err SHALL be mutually exclusive and SHALL be 0 on any edge where clk_en=0.
REQ-023 With clk_en=0, all registers other than the step_valid/err pulse registers SHALL hold; the FILL edge count SHALL not advance.

Reset
REQ-024 rst=1 at a rising edge SHALL set sync1, sync2, prev, bin_out, err_cnt to 0, step_valid, step_up, err, locked to 0, and state to FILL, regardless of clk_en.
REQ-025 rst SHALL take priority over clk_en and over any in-progress step or error detection; a reset in RUN SHALL restart FILL.

Verification
REQ-026 Reset then gray_in=0, clk_en=1: locked=1 after 3rd enabled edge, bin_out=0, no step_valid/err pulses during FILL/PRIME.
REQ-027 N=4, locked, gray_in stepped 00000,00001,00011,00010 one per 4 cycles: bin_out 0,1,2,3 each 3 edges after change; one step_valid per change, step_up=1.
REQ-028 gray_in 10000 (bin 31) -> 00000: step_valid=1, step_up=1, bin_out=0; then 00000 -> 10000: step_valid=1, step_up=0, bin_out=31.
REQ-029 Locked at gray 00001, jump to 00110: err=1 for one cycle, err_cnt 0->1, bin_out=4, step_valid=0; 300 forced errors leave err_cnt=255.
REQ-030 clk_en=0 for 10 cycles while gray_in changes: outputs hold, no pulses; on re-enable, latency resumes from held pipeline.
REQ-031 rst=1 for one edge while locked with err_cnt=7: next cycle err_cnt=0, locked=0, bin_out=0; relock after 3 enabled edges.
